// File: rtl/gin_pkg.sv
// Shared types and helpers for the buffered GIN multicast network.
package gin_pkg;

  // Delivery state of the FIFO head.
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FRESH   = 2'd1,
    PARTIAL = 2'd2
  } gin_state_e;

  // Default geometry, also used by the default entry layout below.
  localparam int unsigned GinXidBits  = 5;
  localparam int unsigned GinYidBits  = 4;
  localparam int unsigned GinDataBits = 32;

  // FIFO entry layout at the default widths; the top derives its own
  // parametrised copy with the same field order.
  typedef struct packed {
    logic [GinYidBits-1:0]  tag_y;
    logic [GinXidBits-1:0]  tag_x;
    logic [GinDataBits-1:0] data;
  } gin_entry_t;

  // Flat PE index of row r, column c.
  function automatic int unsigned pe_idx(input int unsigned r, input int unsigned c,
                                         input int unsigned cols);
    return r * cols + c;
  endfunction

endpackage

// File: rtl/gin_fifo.sv
// Small synchronous FIFO holding GIN entries; head is read combinationally.
module gin_fifo #(
  parameter int unsigned WIDTH = 41,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [AW-1:0]               wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]               count_q, count_d;
  logic                        do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Guard against overflow/underflow even if the caller misbehaves.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Occupancy next-state.
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage array, no reset needed: contents are only read when occupied.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/gin_mcast_buf.sv
// Buffered GIN: multicasts each FIFO head to all PEs whose scanned-in row/PE IDs
// match its tags, tracking per-PE acceptance until every matched PE has taken it.
module gin_mcast_buf
  import gin_pkg::*;
#(
  parameter int unsigned ROWS      = 6,
  parameter int unsigned COLS      = 8,
  parameter int unsigned XID_BITS  = GinXidBits,
  parameter int unsigned YID_BITS  = GinYidBits,
  parameter int unsigned DATA_BITS = GinDataBits,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   GIN_valid,
  output logic                   GIN_ready,
  input  logic [DATA_BITS-1:0]   GIN_data,
  input  logic [XID_BITS-1:0]    tag_X,
  input  logic [YID_BITS-1:0]    tag_Y,
  input  logic                   set_XID,
  input  logic [XID_BITS-1:0]    XID_scan_in,
  input  logic                   set_YID,
  input  logic [YID_BITS-1:0]    YID_scan_in,
  input  logic [ROWS*COLS-1:0]   PE_ready,
  output logic [ROWS*COLS-1:0]   PE_valid,
  output logic [DATA_BITS-1:0]   PE_data,
  output logic                   busy,
  output logic                   drop
);

  localparam int unsigned NPE  = ROWS * COLS;
  localparam int unsigned CNTW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [YID_BITS-1:0]  tag_y;
    logic [XID_BITS-1:0]  tag_x;
    logic [DATA_BITS-1:0] data;
  } entry_t;

  localparam int unsigned EW = $bits(entry_t);

  logic [ROWS-1:0][YID_BITS-1:0] yid_q;
  logic [NPE-1:0][XID_BITS-1:0]  xid_q;

  gin_state_e     state_q, state_d;
  logic [NPE-1:0] pend_q, pend_d;
  logic [NPE-1:0] match, offer, remain;

  entry_t          wr_entry, head;
  logic [EW-1:0]   head_raw;
  logic            fifo_full, fifo_empty;
  logic [CNTW-1:0] fifo_count;
  logic            cfg, push, pop;

  assign cfg       = set_XID | set_YID;
  assign GIN_ready = ~fifo_full & ~cfg & ~rst;
  assign push      = GIN_valid & GIN_ready;
  assign busy      = ~fifo_empty;

  assign wr_entry = '{tag_y: tag_Y, tag_x: tag_X, data: GIN_data};
  assign head     = entry_t'(head_raw);
  assign PE_data  = head.data;

  gin_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .rdata_o (head_raw),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Row-ID and PE-ID scan chains; first value shifted in ends at the far end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      yid_q <= '0;
      xid_q <= '0;
    end else begin
      if (set_YID) begin
        for (int r = ROWS - 1; r > 0; r--) yid_q[r] <= yid_q[r-1];
        yid_q[0] <= YID_scan_in;
      end
      if (set_XID) begin
        for (int i = NPE - 1; i > 0; i--) xid_q[i] <= xid_q[i-1];
        xid_q[0] <= XID_scan_in;
      end
    end
  end

  // Head match mask against the live ID registers.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      assign match[pe_idx(r, c, COLS)] = (yid_q[r] == head.tag_y) &&
                                         (xid_q[pe_idx(r, c, COLS)] == head.tag_x);
    end
  end

  // Delivery FSM: offer the head, retire accepted PEs, pop once nobody is left.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    offer    = '0;
    remain   = '0;
    pop      = 1'b0;
    drop     = 1'b0;
    PE_valid = '0;
    // Config cycles freeze delivery entirely, holding any pending mask.
    if (!cfg) begin
      unique case (state_q)
        EMPTY: begin
          if (push) state_d = FRESH;
        end
        FRESH: begin
          offer = match;
          drop  = (match == '0);
        end
        PARTIAL: begin
          offer = pend_q;
        end
        default: state_d = EMPTY;
      endcase
      if (state_q == FRESH || state_q == PARTIAL) begin
        PE_valid = offer;
        remain   = offer & ~PE_ready;
        pend_d   = remain;
        if (remain == '0) begin
          pop = 1'b1;
          // Next head exists if more than the popped entry is stored or one arrives now.
          state_d = (fifo_count > CNTW'(1) || push) ? FRESH : EMPTY;
        end else begin
          state_d = PARTIAL;
        end
      end
    end
  end

  // FSM state and pending-acceptance mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: doc/gin_mcast_buf.md
# gin_mcast_buf

Buffered, parametrised global input network (GIN) distributing a single input stream to a ROWS×COLS PE array. Each input word carries a (tag_Y, tag_X) pair pushed with the data into an input FIFO. The head word is multicast to every PE whose scanned-in row ID and PE ID match. Per-PE acceptance is tracked, so each matched PE takes the word as soon as it is ready, without waiting for the others. It sits between the slave-SRAM read port and the PE array, in place of the fixed 6-row two-level bus network.

## Interface
- ROWS, 6, number of PE rows
- COLS, 8, PEs per row
- XID_BITS, 5, PE ID / tag_X width
- YID_BITS, 4, row ID / tag_Y width
- DATA_BITS, 32, payload width
- DEPTH, 4, input FIFO entries; power of 2, ≥2
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- GIN_valid  in  1  input word valid
- GIN_ready  out  1  input word accepted when valid & ready
- GIN_data  in  DATA_BITS  payload
- tag_X  in  XID_BITS  column tag, sampled with GIN_data
- tag_Y  in  YID_BITS  row tag, sampled with GIN_data
- set_XID  in  1  shift PE-ID chain one step
- XID_scan_in  in  XID_BITS  PE-ID chain input
- set_YID  in  1  shift row-ID chain one step
- YID_scan_in  in  YID_BITS  row-ID chain input
- PE_ready  in  ROWS*COLS  per-PE ready; bit index r*COLS+c
- PE_valid  out  ROWS*COLS  per-PE valid
- PE_data  out  DATA_BITS  head payload, shared by all PEs
- busy  out  1  FIFO non-empty
- drop  out  1  one-cycle pulse: head matched no PE and was discarded

## Operation
- ID chains: on each set_YID cycle, yid[0]←YID_scan_in and yid[r]←yid[r-1]. On each set_XID cycle, xid[0]←XID_scan_in and xid[i]←xid[i-1] over all ROWS*COLS entries. After N shifts, the first value shifted in sits at index N-1. All IDs reset to 0.
- Config cycles (set_XID|set_YID) force GIN_ready=0 and PE_valid=0. Delivery freezes and pending state is held. Matching always uses current ID registers.
- FIFO: entry = {tag_Y, tag_X, data}. Push on GIN_valid&GIN_ready. GIN_ready = !full & !config. No same-cycle bypass when full.
- Match mask M[i] = (yid[i/COLS]==head.tag_Y) & (xid[i]==head.tag_X).
- Delivery FSM:
  - EMPTY: FIFO empty. PE_valid=0.
  - FRESH: new head. PE_valid=M.
  - PARTIAL: PE_valid=pend.
- Handshake: a PE accepts the word when PE_valid[i]&PE_ready[i]. Each cycle, pend ← PE_valid & ~(PE_valid&PE_ready).
- Pop when the remaining mask after this cycle's acceptances is 0. After a pop, the state becomes FRESH if the FIFO is still non-empty, otherwise EMPTY. Otherwise FRESH→PARTIAL.
- Zero match: in FRESH with M==0, pop that cycle and pulse drop. No PE_valid is raised.
- PE_data = head.data whenever the FIFO is non-empty. Its value is don't-care when empty.
- A PE never sees PE_valid twice for the same entry. PE_valid bits never deassert before their handshake, except during config cycles.

## Timing
- Reset: GIN_ready=0 while rst is high. After rst falls: GIN_ready=1, PE_valid=0, busy=0, drop=0. FIFO pointers, count, pend and FSM are cleared asynchronously.
- Latency: a word pushed at cycle t appears on PE_valid at t+1 if the FIFO was empty.
- Throughput: one word per cycle when all matched PEs are ready.
- Full FIFO: GIN_ready=0 until the cycle after a pop.
- Push and pop in the same cycle are legal when not full; count is unchanged.
- Reset mid-delivery: the entry is lost, with no further PE_valid.

## Structure
- Package gin_pkg: entry struct type, FSM enum {EMPTY, FRESH, PARTIAL}, and the index helper r*COLS+c.
- Sub-module gin_fifo: parametrised DEPTH×entry FIFO with full/empty/count. The FSM, ID chains and match logic live in the top level.

## Test plan
- ID scan: shift YID 5,4,3,2,1,0 and XID i%8 for i=47..0 (48 shifts). Read back: yid[r]=r, xid[i]=i%8.
- Multicast: tag_Y=2, tag_X=3, data=0xA5A5_0001. Only PE 19 gets PE_valid=1 at t+1. With PE_ready=1, pop occurs and busy drops at t+2.
- Partial acceptance: set all xid=0, send tag_X=0, tag_Y=1. PEs 8..15 valid. Ready PEs 8..11 in cycle 1 and 12..15 in cycle 3. Valid bits clear individually; pop after cycle 3.
- Zero match: tag_Y=15. drop pulses 1 cycle after push, no PE_valid, busy returns to 0.
- Backpressure: PE_ready=0 and push 5 words. GIN_ready=0 after 4 words. Release PE_ready and words are delivered in order, one per cycle.
- Config stall and reset: assert set_XID during PARTIAL; PE_valid=0 and pend is held. Then assert rst mid-delivery; all outputs take reset values immediately.
